// File: rtl/micro_sequencer.sv
// micro_sequencer: hardwired T-state sequencer and control-word generator for
// the 8-bit bus CPU. It walks T1..T6 and decodes one control word per state
// from the state, the IR opcode and the ALU flags. Instructions end as soon as
// their last useful state is done (EARLY_END=1) or are padded out to T6.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   operate_code[3:0]   IR opcode, valid from T4
//   carry, zero         ALU flags, consulted only in T4
//   step_mode, step     single-instruction stepping (MICRO_SEQUENCER_STEP_EN only)
//   t[5:0]              one-hot T-state, 0 while halted
//   ep lm cp epr li ei  PC->bus, load MAR, PC++, RAM->bus, load IR, IR operand->bus
//   la ea lb su eu lo lp load A, A->bus, load B, subtract, ALU->bus, load OUT, load PC
//   halted              sequencer is in HALT
//   instr_done          last executed T-state of the current instruction
//
// Optional feature: define MICRO_SEQUENCER_STEP_EN to add step_mode/step.
module micro_sequencer #(
  parameter bit         EARLY_END = 1'b1,
  parameter logic [3:0] OUT_OP    = 4'hE,
  parameter logic [3:0] HLT_OP    = 4'hF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] operate_code,
  input  logic       carry,
  input  logic       zero,
`ifdef MICRO_SEQUENCER_STEP_EN
  input  logic       step_mode,
  input  logic       step,
`endif
  output logic [5:0] t,
  output logic       ep,
  output logic       lm,
  output logic       cp,
  output logic       epr,
  output logic       li,
  output logic       ei,
  output logic       la,
  output logic       ea,
  output logic       lb,
  output logic       su,
  output logic       eu,
  output logic       lo,
  output logic       lp,
  output logic       halted,
  output logic       instr_done
);

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_JMP = 4'h4;
  localparam logic [3:0] OP_JC  = 4'h5;
  localparam logic [3:0] OP_JZ  = 4'h6;

  typedef enum logic [2:0] {S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT} state_e;

  state_e state_q, state_d;
  logic   fin;    // last useful execute state of this instruction
  logic   pause;  // hold at the T1 boundary with all controls off

`ifdef MICRO_SEQUENCER_STEP_EN
  logic step_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) step_q <= 1'b0;
    else      step_q <= step;
  end
  // Only the T1 boundary looks at the step edge, so edges that land
  // mid-instruction are simply lost. While reset is held, T1 still decodes.
  assign pause = step_mode & rst & (state_q == S_T1) & ~(step & ~step_q);
`else
  assign pause = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_T1;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    t          = 6'b000000;
    {ep, lm, cp, epr, li, ei, la, ea, lb, su, eu, lo, lp} = '0;
    halted     = 1'b0;
    instr_done = 1'b0;
    fin        = 1'b0;
    case (state_q)
      S_T1: begin
        t = 6'b000001;
        if (!pause) begin
          ep = 1'b1; lm = 1'b1; state_d = S_T2;
        end
      end
      S_T2: begin
        t = 6'b000010; cp = 1'b1; state_d = S_T3;
      end
      S_T3: begin
        t = 6'b000100; epr = 1'b1; li = 1'b1; state_d = S_T4;
      end
      S_T4: begin
        t = 6'b001000;
        state_d = S_T5;
        if (operate_code == HLT_OP) begin
          // HLT finishes here in both modes; there is no padding before HALT.
          instr_done = 1'b1;
          state_d    = S_HALT;
        end else if (operate_code == OUT_OP) begin
          ea = 1'b1; lo = 1'b1; fin = 1'b1;
        end else begin
          case (operate_code)
            OP_LDA, OP_ADD, OP_SUB: begin ei = 1'b1; lm = 1'b1; end
            OP_JMP: begin ei = 1'b1;  lp = 1'b1;  fin = 1'b1; end
            OP_JC:  begin ei = carry; lp = carry; fin = 1'b1; end
            OP_JZ:  begin ei = zero;  lp = zero;  fin = 1'b1; end
            default: fin = 1'b1;  // NOP
          endcase
        end
      end
      S_T5: begin
        t = 6'b010000;
        state_d = S_T6;
        case (operate_code)
          OP_LDA: begin epr = 1'b1; la = 1'b1; fin = 1'b1; end
          OP_ADD: begin epr = 1'b1; lb = 1'b1; end
          OP_SUB: begin epr = 1'b1; lb = 1'b1; su = 1'b1; end
          default: ;  // padding state
        endcase
      end
      S_T6: begin
        t = 6'b100000;
        state_d    = S_T1;
        instr_done = 1'b1;
        if (operate_code == OP_ADD || operate_code == OP_SUB) begin
          eu = 1'b1; la = 1'b1; su = (operate_code == OP_SUB);
        end
      end
      S_HALT: halted = 1'b1;  // only reset leaves
      default: state_d = S_T1;
    endcase
    // Early return to T1; otherwise the chain runs on to T6 with idle states.
    if (fin && EARLY_END) begin
      instr_done = 1'b1;
      state_d    = S_T1;
    end
  end

endmodule

// File: tb/tb_micro_sequencer.sv
// Bench for micro_sequencer: instance 0 runs with EARLY_END=1, instance 1 with
// EARLY_END=0. Each is exercised in turn while the other is held in reset.
// Expected control words come from a per-opcode microstep table.
module tb_micro_sequencer;
  localparam logic [12:0] EP = 13'h1000, LM = 13'h0800, CP = 13'h0400, EPR = 13'h0200,
                          LI = 13'h0100, EI = 13'h0080, LA = 13'h0040, EA  = 13'h0020,
                          LB = 13'h0010, SU = 13'h0008, EU = 13'h0004, LO  = 13'h0002,
                          LP = 13'h0001;
  localparam logic [12:0] BUSDRV = EP | EPR | EI | EA | EU;

  logic        clk = 1'b0;
  logic        rstn [2];
  logic [3:0]  opc  [2];
  logic        cy   [2];
  logic        zr   [2];
  logic [5:0]  tv   [2];
  logic        hlt  [2];
  logic        done [2];
  logic [12:0] ctl  [2];
  logic        smode, stp;
  int          nvec = 0, nerr = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic ep, lm, cp, epr, li, ei, la, ea, lb, su, eu, lo, lp;
    micro_sequencer #(.EARLY_END(g == 0)) u (
      .clk(clk), .rst(rstn[g]), .operate_code(opc[g]), .carry(cy[g]), .zero(zr[g]),
`ifdef MICRO_SEQUENCER_STEP_EN
      .step_mode(g == 0 ? smode : 1'b0), .step(g == 0 ? stp : 1'b0),
`endif
      .t(tv[g]), .ep(ep), .lm(lm), .cp(cp), .epr(epr), .li(li), .ei(ei), .la(la),
      .ea(ea), .lb(lb), .su(su), .eu(eu), .lo(lo), .lp(lp),
      .halted(hlt[g]), .instr_done(done[g]));
    assign ctl[g] = {ep, lm, cp, epr, li, ei, la, ea, lb, su, eu, lo, lp};
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Bus-driver exclusivity, every cycle, both instances.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++)
      chk($sformatf("u%0d excl", i), 32'($countones(ctl[i] & BUSDRV) <= 1), 32'd1);
  end

  // Reference microprogram: control word per T-state and instruction length.
  function automatic void build(input bit early, input logic [3:0] op, input bit c,
                                input bit z, output logic [12:0] w [6], output int n);
    w[0] = EP | LM; w[1] = CP; w[2] = EPR | LI; w[3] = '0; w[4] = '0; w[5] = '0;
    n = 4;
    case (op)
      4'h0: begin w[3] = EI | LM; w[4] = EPR | LA; n = 5; end
      4'h1: begin w[3] = EI | LM; w[4] = EPR | LB; w[5] = EU | LA; n = 6; end
      4'h2: begin w[3] = EI | LM; w[4] = EPR | LB | SU; w[5] = EU | LA | SU; n = 6; end
      4'h4: w[3] = EI | LP;
      4'h5: w[3] = c ? (EI | LP) : 13'h0;
      4'h6: w[3] = z ? (EI | LP) : 13'h0;
      4'hE: w[3] = EA | LO;
      default: ;
    endcase
    if (!early && op != 4'hF) n = 6;
  endfunction

  // Runs one instruction from T1 (entered just after a rising edge).
  // abort_at >= 0 asserts reset inside that T-state and ends the instruction.
  task automatic run_instr(input int s, input logic [3:0] op, input bit c, input bit z,
                           input int abort_at);
    logic [12:0] w [6];
    int n;
    build(s == 0, op, c, z, w, n);
    for (int k = 0; k < n; k++) begin
      opc[s] = (k < 3) ? 4'($urandom) : op;
      cy[s]  = (k == 3) ? c : 1'($urandom);
      zr[s]  = (k == 3) ? z : 1'($urandom);
      @(negedge clk);
      chk($sformatf("u%0d op%0h T%0d t", s, op, k + 1), tv[s], 32'(1 << k));
      chk($sformatf("u%0d op%0h T%0d ctl", s, op, k + 1), ctl[s], w[k]);
      chk($sformatf("u%0d op%0h T%0d done", s, op, k + 1), done[s], (k == n - 1));
      chk($sformatf("u%0d op%0h T%0d halted", s, op, k + 1), hlt[s], 0);
      if (k == abort_at) begin
        #2 rstn[s] = 1'b0;
        #1;
        chk($sformatf("u%0d abort t", s), tv[s], 1);
        chk($sformatf("u%0d abort ctl", s), ctl[s], EP | LM);
        @(posedge clk); #1;
        chk($sformatf("u%0d abort hold ctl", s), ctl[s], EP | LM);
        rstn[s] = 1'b1;
        return;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic halt_chk(input int s, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      opc[s] = 4'($urandom); cy[s] = 1'($urandom); zr[s] = 1'($urandom);
      @(negedge clk);
      chk($sformatf("u%0d halt t", s), tv[s], 0);
      chk($sformatf("u%0d halt ctl", s), ctl[s], 0);
      chk($sformatf("u%0d halt flag", s), hlt[s], 1);
      chk($sformatf("u%0d halt done", s), done[s], 0);
      @(posedge clk); #1;
    end
  endtask

  // Asynchronous reset out of wherever the instance is; ends in T1 after an edge.
  task automatic reset_out(input int s);
    @(negedge clk); #1 rstn[s] = 1'b0;
    #1;
    chk($sformatf("u%0d rst t", s), tv[s], 1);
    chk($sformatf("u%0d rst halted", s), hlt[s], 0);
    chk($sformatf("u%0d rst ctl", s), ctl[s], EP | LM);
    @(posedge clk); #1 rstn[s] = 1'b1;
  endtask

  task automatic pause_chk(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      chk("pause t", tv[0], 1);
      chk("pause ctl", ctl[0], 0);
      chk("pause done", done[0], 0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rstn[0] = 1'b0; rstn[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin opc[i] = '0; cy[i] = 1'b0; zr[i] = 1'b0; end
    smode = 1'b0; stp = 1'b0;

    @(negedge clk);
    chk("reset t", tv[0], 1);
    chk("reset ctl", ctl[0], EP | LM);
    chk("reset halted", hlt[0], 0);
    @(posedge clk); #1 rstn[0] = 1'b1;

    // EARLY_END=1: directed set, then a random stream.
    run_instr(0, 4'h0, 0, 0, -1);
    run_instr(0, 4'h1, 0, 0, -1);
    run_instr(0, 4'h2, 1, 1, -1);
    run_instr(0, 4'h5, 0, 1, -1);
    run_instr(0, 4'h5, 1, 0, -1);
    run_instr(0, 4'h6, 1, 0, -1);
    run_instr(0, 4'h6, 0, 1, -1);
    run_instr(0, 4'h4, 0, 0, -1);
    run_instr(0, 4'h3, 1, 1, -1);
    for (int i = 0; i < 40; i++)
      run_instr(0, 4'($urandom_range(0, 14)), 1'($urandom), 1'($urandom), -1);
    run_instr(0, 4'h1, 0, 0, 4);   // reset lands in T5 of ADD
    run_instr(0, 4'h0, 0, 0, -1);
    run_instr(0, 4'hE, 0, 0, -1);
    run_instr(0, 4'hF, 0, 0, -1);
    halt_chk(0, 20);
    reset_out(0);
    run_instr(0, 4'h1, 1, 0, -1);

`ifdef MICRO_SEQUENCER_STEP_EN
    smode = 1'b1;
    pause_chk(3);
    stp = 1'b1;
    run_instr(0, 4'h1, 0, 0, -1);
    pause_chk(3);
    stp = 1'b0;
    pause_chk(1);
    stp = 1'b1;
    run_instr(0, 4'h0, 0, 0, -1);
    pause_chk(2);
    smode = 1'b0; stp = 1'b0;
    run_instr(0, 4'h4, 0, 0, -1);
`endif

    // EARLY_END=0 on the second instance.
    rstn[0] = 1'b0;
    rstn[1] = 1'b1;
    run_instr(1, 4'h0, 0, 0, -1);
    run_instr(1, 4'h1, 0, 0, -1);
    run_instr(1, 4'h2, 0, 0, -1);
    run_instr(1, 4'h5, 1, 0, -1);
    run_instr(1, 4'h6, 0, 0, -1);
    for (int i = 0; i < 30; i++)
      run_instr(1, 4'($urandom_range(0, 14)), 1'($urandom), 1'($urandom), -1);
    run_instr(1, 4'hF, 0, 0, -1);
    halt_chk(1, 5);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/micro_sequencer.md
Name: micro_sequencer

Overview:
- Hardwired T-state sequencer and control-word generator for the 8-bit bus CPU.
- Drives the PC, memory, IR, register group, ALU and output unit. Together they share the 8-bit bus w.
- Replaces the fixed 6-beat ring, so each instruction runs only the T-states it needs.
- Fetch, decode and execute flow, conditional jumps and halt are sequenced here; bus-driver exclusivity is guaranteed by construction.

Parameters:
EARLY_END, 1, 1 = an instruction returns to T1 after its last useful state; 0 = every instruction runs T1..T6 and pads with idle states.
OUT_OP, 4'hE, opcode for OUT.
HLT_OP, 4'hF, opcode for HLT.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst  input  1  asynchronous active-low reset.
operate_code  input  4  opcode from the IR; valid from T4 onward.
carry  input  1  ALU carry flag, registered elsewhere.
zero  input  1  accumulator zero flag, registered elsewhere.
t  output  6  one-hot T-state; t[0]=T1 .. t[5]=T6; 6'b0 while halted.
ep, lm, cp, epr, li, ei  output  1 each  PC to bus, load MAR, PC increment, RAM to bus, load IR, IR operand to bus.
la, ea, lb, su, eu, lo, lp  output  1 each  load A, A to bus, load B, subtract, ALU to bus, load output, load PC (jump).
halted  output  1  high in the HALT state.
instr_done  output  1  high during the last executed T-state of each instruction.

Behaviour:
- State register values: T1..T6 and HALT.
- Control outputs, t and instr_done are decoded combinationally from the state register, operate_code and the flags. They have no registered latency.
- rst low, asynchronously: state goes to T1, t=6'b000001, halted=0. The first rising edge after release moves to T2.
- With reset asserted the control outputs still decode T1 (ep=1, lm=1, all others 0).
- Fetch, common to all instructions:
  - T1: ep, lm.
  - T2: cp.
  - T3: epr, li.
- Execute, starting at T4:
  - LDA (0000): T4 ei, lm. T5 epr, la; end.
  - ADD (0001): T4 ei, lm. T5 epr, lb. T6 eu, la; end.
  - SUB (0010): same as ADD, with su high in T5 and T6.
  - JMP (0100): T4 ei, lp; end.
  - JC (0101): T4 ei, lp only if carry=1, otherwise no controls; end.
  - JZ (0110): T4 ei, lp only if zero=1, otherwise no controls; end.
  - OUT_OP: T4 ea, lo; end.
  - HLT_OP: T4 no controls. The next edge goes to HALT.
  - Any other opcode: NOP; T4 no controls; end.
- Flags are sampled combinationally in T4 only. A flag change at any other time has no effect.
- On "end" with EARLY_END=1: instr_done=1 in that state and the next state is T1.
- With EARLY_END=0:
  - The remaining states up to T6 issue no controls.
  - instr_done=1 in T6 only.
  - T6 goes to T1.
- HALT:
  - All controls 0, t=0, halted=1.
  - The block stays in HALT until rst is asserted; there is no other exit.
  - instr_done=1 in the HLT T4 state.
- Invariant: at most one of ep, epr, ei, ea, eu is high in any cycle.
- Reset mid-instruction returns to T1 immediately. No partial control pulse follows the reset release.

Optional Feature:
- Macro MICRO_SEQUENCER_STEP_EN adds input step_mode (1 bit) and input step (1 bit). step is synchronous to clk.
- With the macro:
  - When step_mode=1 and the state is T1 at an instruction boundary, the sequencer holds in a PAUSE condition: state stays T1, all controls 0, t=6'b000001.
  - It advances one full instruction after a rising edge of step, detected by an internal registered copy of step that resets to 0.
  - step_mode=0 runs freely.
  - Step edges arriving mid-instruction are ignored.
- Without the macro: the ports are absent and the sequencer always runs freely.

Test Plan:
- Reset, then LDA with EARLY_END=1 -> T1 ep+lm; T2 cp; T3 epr+li; T4 ei+lm; T5 epr+la with instr_done=1; next cycle t=6'b000001.
- ADD then SUB -> 6 states each; su=1 only in SUB T5/T6; eu+la in T6; with EARLY_END=0 an LDA shows no controls in T6 and instr_done in T6.
- JC with carry=0, then with carry=1 -> lp=0 / lp=1 in T4 and ei matches; same pair for JZ with zero.
- OUT_OP then HLT_OP -> ea+lo in T4 of OUT; HLT enters HALT with t=0, halted=1 and stays there for 20 cycles; rst low leaves HALT to T1.
- Assert rst during T5 of ADD -> immediate T1, la never pulses; bus-driver exclusivity checked by assertion in every cycle.
- With MICRO_SEQUENCER_STEP_EN and step_mode=1 -> held at T1 with controls 0; one step pulse yields exactly one instruction, then the sequencer holds again.
